// File: rtl/trigger_capture_buffer.sv
// Trigger-captured ring buffer: records wide ADC beats, freezes a record
// around a laser trigger, then replays it one sample per AXI-Stream transfer.
module trigger_capture_buffer #(
    parameter int unsigned SAMPLE_WIDTH           = 16,
    parameter int unsigned SAMPLES_PER_BEAT       = 12,
    parameter int unsigned DEPTH                  = 64,
    parameter int unsigned PRETRIG                = 0,
    parameter int unsigned SIGN_EXTEND            = 1,
    parameter int unsigned C_S00_AXIS_TDATA_WIDTH = 192,
    parameter int unsigned C_M00_AXIS_TDATA_WIDTH = 32
) (
    input  logic                                  s00_axis_aclk,
    input  logic                                  s00_axis_aresetn,
    input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
    input  logic                                  s00_axis_tvalid,
    input  logic                                  s00_axis_tlast,
    input  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0]   s00_axis_tstrb,
    output logic                                  s00_axis_tready,
    output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
    output logic                                  m00_axis_tvalid,
    output logic                                  m00_axis_tlast,
    output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0]   m00_axis_tstrb,
    input  logic                                  m00_axis_tready,
    input  logic                                  laser_trigger,
    output logic                                  busy,
    output logic [15:0]                           missed_triggers
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CW    = $clog2(DEPTH + 1);
    localparam int unsigned POST  = DEPTH - PRETRIG;
    localparam int unsigned TOTAL = DEPTH * SAMPLES_PER_BEAT;
    localparam int unsigned OW    = $clog2(TOTAL + 1);
    localparam int unsigned IW    = (SAMPLES_PER_BEAT > 1) ? $clog2(SAMPLES_PER_BEAT) : 1;

    typedef enum logic [1:0] {ARMED, CAPTURE, DUMP} state_t;

    state_t state, state_next;

    logic [C_S00_AXIS_TDATA_WIDTH-1:0] mem [DEPTH];
    logic [C_S00_AXIS_TDATA_WIDTH-1:0] rd_data;
    logic [SAMPLE_WIDTH-1:0]           lane [SAMPLES_PER_BEAT];
    logic [SAMPLE_WIDTH-1:0]           cur_sample;
    logic [C_M00_AXIS_TDATA_WIDTH-1:0] ext_sample;
    logic [AW-1:0] wr_ptr, rd_addr;
    logic [CW-1:0] pre_cnt, post_cnt;
    logic [OW-1:0] out_cnt;
    logic [IW-1:0] idx;
    logic rd_loaded;
    logic accept, pre_full, trig_start, miss, post_done, handshake;
    logic fetch_first, advance, beat_end, last_load, fetch;
    logic unused_inputs;

    assign m00_axis_tstrb = '1;
    assign unused_inputs  = ^{s00_axis_tlast, s00_axis_tstrb};

    // Handshake and pipeline strobes shared by the FSM and the datapath.
    always_comb begin
        accept      = s00_axis_tvalid & s00_axis_tready;
        handshake   = m00_axis_tvalid & m00_axis_tready;
        pre_full    = (pre_cnt == CW'(PRETRIG));
        trig_start  = (state == ARMED) && laser_trigger && pre_full;
        miss        = laser_trigger && !trig_start;
        post_done   = accept && (CW'(post_cnt + CW'(1)) == CW'(POST));
        fetch_first = (state == DUMP) && !rd_loaded && (out_cnt == '0);
        advance     = (state == DUMP) && rd_loaded && (!m00_axis_tvalid || m00_axis_tready);
        beat_end    = (idx == IW'(SAMPLES_PER_BEAT - 1));
        last_load   = (out_cnt == OW'(TOTAL - 1));
        fetch       = fetch_first || (advance && beat_end && !last_load);
    end

    // Pick the current sample out of the held beat and widen it.
    always_comb begin
        for (int unsigned j = 0; j < SAMPLES_PER_BEAT; j++) begin
            lane[j] = rd_data[j*SAMPLE_WIDTH +: SAMPLE_WIDTH];
        end
        cur_sample = lane[idx];
        ext_sample = '0;
        ext_sample[SAMPLE_WIDTH-1:0] = cur_sample;
        if (SIGN_EXTEND != 0) begin
            for (int unsigned i = SAMPLE_WIDTH; i < C_M00_AXIS_TDATA_WIDTH; i++) begin
                ext_sample[i] = cur_sample[SAMPLE_WIDTH-1];
            end
        end
    end

    // State register.
    always_ff @(posedge s00_axis_aclk) begin
        if (!s00_axis_aresetn) state <= ARMED;
        else                   state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            ARMED:   if (trig_start) state_next = post_done ? DUMP : CAPTURE;
            CAPTURE: if (post_done) state_next = DUMP;
            DUMP:    if (handshake && m00_axis_tlast) state_next = ARMED;
            default: state_next = ARMED;
        endcase
    end

    // Ring storage with a one-cycle registered read port.
    always_ff @(posedge s00_axis_aclk) begin
        if (accept) mem[wr_ptr] <= s00_axis_tdata;
        if (fetch)  rd_data     <= mem[rd_addr];
    end

    // Pointers, counters and the registered master-stream outputs.
    always_ff @(posedge s00_axis_aclk) begin
        if (!s00_axis_aresetn) begin
            wr_ptr          <= '0;
            rd_addr         <= '0;
            pre_cnt         <= '0;
            post_cnt        <= '0;
            out_cnt         <= '0;
            idx             <= '0;
            rd_loaded       <= 1'b0;
            missed_triggers <= '0;
            m00_axis_tvalid <= 1'b0;
            m00_axis_tlast  <= 1'b0;
            m00_axis_tdata  <= '0;
            busy            <= 1'b0;
            s00_axis_tready <= 1'b1;
        end else begin
            busy            <= (state_next != ARMED);
            s00_axis_tready <= (state_next != DUMP);
            if (miss && (missed_triggers != 16'hFFFF)) missed_triggers <= missed_triggers + 16'd1;
            if (accept) wr_ptr <= wr_ptr + AW'(1);
            case (state)
                ARMED: begin
                    if (accept && !pre_full) pre_cnt <= pre_cnt + CW'(1);
                    if (trig_start) begin
                        // Record starts PRETRIG beats behind the write pointer.
                        rd_addr  <= wr_ptr - AW'(PRETRIG);
                        post_cnt <= CW'(accept);
                    end
                end
                CAPTURE: begin
                    if (accept) post_cnt <= post_cnt + CW'(1);
                end
                DUMP: begin
                    if (fetch)       rd_addr   <= rd_addr + AW'(1);
                    if (fetch_first) rd_loaded <= 1'b1;
                    if (advance) begin
                        m00_axis_tdata  <= ext_sample;
                        m00_axis_tvalid <= 1'b1;
                        m00_axis_tlast  <= last_load;
                        out_cnt         <= out_cnt + OW'(1);
                        idx             <= beat_end ? '0 : idx + IW'(1);
                        if (beat_end && last_load) rd_loaded <= 1'b0;
                    end else if (handshake) begin
                        m00_axis_tvalid <= 1'b0;
                        m00_axis_tlast  <= 1'b0;
                    end
                    if (state_next == ARMED) begin
                        pre_cnt   <= '0;
                        post_cnt  <= '0;
                        out_cnt   <= '0;
                        idx       <= '0;
                        rd_loaded <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
